window_mem_server: RTL and testbench

//  Memory-side responder for the window handler's load protocol. It owns a packed-byte frame buffer that a host

---
 rtl/window_mem_server_pkg.sv | 37 +++
 rtl/window_mem_server_if.sv | 37 +++
 rtl/window_mem_server_frame_ram.sv | 35 +++
 rtl/window_mem_server.sv | 156 +++++++++++++++
 tb/tb_window_mem_server.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_mem_server_pkg.sv
// window_pkg: shared frame/window geometry, server state encoding and the expected window-count helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package window_pkg;

  localparam int FRAME_ROWS     = 240;
  localparam int FRAME_WORDS    = 80;
  localparam int WIN_ROWS       = 80;
  localparam int WIN_WORDS      = 20;
  localparam int TIMEOUT        = 8192;

  localparam int WIN_PX         = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  localparam int DEPTH          = FRAME_ROWS * FRAME_WORDS;
  localparam int AW             = $clog2(DEPTH);
  localparam int CW             = 13;
  localparam int SERVE_LEN      = WIN_ROWS * WIN_WORDS;
  localparam int SW             = $clog2(SERVE_LEN);
  localparam int TW             = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SERVE  = 2'd2,
    STREAM = 2'd3
  } srv_state_e;

  // Number of 16x16 windows the handler slides over a rows x (words*4 px) load window.
  function automatic logic [CW-1:0] expected_windows(input int rows, input int words);
    return CW'((rows - WIN_PX + 1) * (words * BYTES_PER_WORD - WIN_PX + 1));
  endfunction

  localparam logic [CW-1:0] EXP_WINDOWS = expected_windows(WIN_ROWS, WIN_WORDS);

endpackage

// File: rtl/window_mem_server_if.sv
// window_mem_server_if: handler <-> memory-server load and window-stream signals.
// Latency: none (wires only); input_data follows row/col by one cycle inside the server.
// Backpressure: en is held by the server until the handler raises ack.
interface window_mem_server_if;
  import window_pkg::*;

  logic              en;
  logic              ack;
  logic [6:0]        row;
  logic [6:0]        col;
  logic [WORD_W-1:0] input_data;
  logic              window_ready;
  logic              done;

  // Handler side: acknowledges the request, issues word requests, streams windows.
  modport master (
    input  en,
    input  input_data,
    output ack,
    output row,
    output col,
    output window_ready,
    output done
  );

  // Memory-server side.
  modport slave (
    output en,
    output input_data,
    input  ack,
    input  row,
    input  col,
    input  window_ready,
    input  done
  );

endinterface

// File: rtl/window_mem_server_frame_ram.sv
// window_frame_ram: single-write, single registered-read word store holding one packed-byte frame.
// Latency: rd_data valid one cycle after rd_addr/rd_en; rd_data holds while rd_en is low.
// Backpressure: none; writes outside the frame are ignored.
module window_frame_ram
  import window_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < AW'(DEPTH))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; output register is cleared by reset and holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/window_mem_server.sv
// window_mem_server: host-loaded frame buffer that serves one load window to the handler and counts its windows.
// Latency: input_data one cycle after row/col; frame_done/start_err/wr_err/timeout_err pulse one cycle after cause.
// Backpressure: en held until ack; optional watchdog (WINDOW_MEM_SERVER_TIMEOUT_EN) bounds waits in REQ/STREAM.
module window_mem_server
  import window_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  input  logic [7:0]        base_row,
  input  logic [6:0]        base_col,
  window_mem_server_if.slave hif,
  output logic              busy,
  output logic              frame_done,
  output logic              count_ok,
  output logic [CW-1:0]     win_count,
  output logic              start_err,
  output logic              wr_err
`ifdef WINDOW_MEM_SERVER_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  srv_state_e    state;
  srv_state_e    state_d;
  logic [7:0]    base_row_q;
  logic [6:0]    base_col_q;
  logic [SW-1:0] served;
  logic          start_ok;
  logic          start_acc;
  logic [CW-1:0] win_count_nxt;
  logic [AW:0]   rd_addr_full;
  logic          rd_en;
  logic          ram_we;
  logic          tmo_hit;

  // The whole load window must fit inside the frame.
  assign start_ok  = (({1'b0, base_row} + 9'(WIN_ROWS)) <= 9'(FRAME_ROWS)) &&
                     (({1'b0, base_col} + 8'(WIN_WORDS)) <= 8'(FRAME_WORDS));
  assign start_acc = (state == IDLE) && start && start_ok;

  // Frame address of the handler's window-relative request; one bit wider than the RAM index.
  assign rd_addr_full = ((AW+1)'(base_row_q) + (AW+1)'(hif.row)) * (AW+1)'(FRAME_WORDS)
                      + (AW+1)'(base_col_q) + (AW+1)'(hif.col);
  assign rd_en  = (state == SERVE) && (rd_addr_full < (AW+1)'(DEPTH));
  assign ram_we = wr_en && (state == IDLE) && !rst;

  // Window counter saturates rather than wrapping.
  assign win_count_nxt = (hif.window_ready && (win_count != '1)) ? win_count + 1'b1 : win_count;

`ifdef WINDOW_MEM_SERVER_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = ((state == REQ) || (state == STREAM)) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in REQ/STREAM, restarting on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if ((state_d != state) || !((state == REQ) || (state == STREAM))) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: one pass per load window; the watchdog overrides any waiting state.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_acc) state_d = REQ;
      REQ:     if (hif.ack) state_d = SERVE;
      SERVE:   if (served == SW'(SERVE_LEN - 1)) state_d = STREAM;
      STREAM:  if (hif.done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    hif.en = (state == REQ);
    busy   = (state != IDLE);
  end

  // Datapath: bases, served-word counter, window count and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_row_q <= '0;
      base_col_q <= '0;
      served     <= '0;
      win_count  <= '0;
      frame_done <= 1'b0;
      count_ok   <= 1'b0;
      start_err  <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      start_err  <= start && !start_acc;
      wr_err     <= wr_en && (state != IDLE);
      frame_done <= 1'b0;
      count_ok   <= 1'b0;
      if (start_acc) begin
        base_row_q <= base_row;
        base_col_q <= base_col;
        win_count  <= '0;
      end
      if ((state == REQ) && hif.ack) begin
        served <= '0;
      end
      if (state == SERVE) begin
        served <= served + 1'b1;
      end
      if (state == STREAM) begin
        win_count <= win_count_nxt;
        if (hif.done) begin
          frame_done <= 1'b1;
          count_ok   <= (win_count_nxt == EXP_WINDOWS);
        end
      end
    end
  end

  window_frame_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_full[AW-1:0]),
    .rd_data (hif.input_data)
  );

endmodule

// File: tb/tb_window_mem_server.sv
// tb_window_mem_server: table-driven start/serve/stream runs plus hand-written corner sequences, checked against a frame model.
// Latency: expects input_data one cycle after row/col and status pulses one cycle after their cause.
// Backpressure: bench plays the handler, withholding ack for a few cycles to observe en being held.
module tb_window_mem_server;
  import window_pkg::*;

  localparam int F_WORDS = 80;
  localparam int W_ROWS  = 80;
  localparam int W_WORDS = 20;
  localparam int EXP_WIN = (W_ROWS - 15) * (W_WORDS * 4 - 15);
  localparam int SAT     = 8191;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          start;
  logic [7:0]    base_row;
  logic [6:0]    base_col;
  logic          busy;
  logic          frame_done;
  logic          count_ok;
  logic [12:0]   win_count;
  logic          start_err;
  logic          wr_err;
`ifdef WINDOW_MEM_SERVER_TIMEOUT_EN
  logic          timeout_err;
`endif

  window_mem_server_if hif();

  window_mem_server dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .base_row   (base_row),
    .base_col   (base_col),
    .hif        (hif),
    .busy       (busy),
    .frame_done (frame_done),
    .count_ok   (count_ok),
    .win_count  (win_count),
    .start_err  (start_err),
    .wr_err     (wr_err)
`ifdef WINDOW_MEM_SERVER_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    int br;
    int bc;
    bit accept;
    int n;
    bit rwd;
    bit exp_ok;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_addr(input int br, input int bc, input int r, input int c);
    return (br + r) * F_WORDS + bc + c;
  endfunction

  task automatic write_word(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_start(input int br, input int bc, input bit accept,
                          input bit wr, input int waddr, input logic [31:0] wdata);
    base_row = 8'(br); base_col = 7'(bc); start = 1'b1;
    if (wr) begin
      wr_en = 1'b1; wr_addr = AW'(waddr); wr_data = wdata;
      ref_mem[waddr] = wdata;
    end
    step();
    start = 1'b0; wr_en = 1'b0;
    check("start_err", start_err, 32'(!accept));
    check("busy_after_start", busy, 32'(accept));
    check("en_after_start", hif.en, 32'(accept));
    if (wr) check("wr_err_idle_write", wr_err, 0);
    if (!accept) begin
      step();
      check("start_err_clears", start_err, 0);
      check("en_stays_low", hif.en, 0);
    end
  endtask

  task automatic handshake(input int delay);
    for (int d = 0; d < delay; d++) begin
      step();
      check("en_held_until_ack", hif.en, 1);
    end
    hif.ack = 1'b1;
    step();
    hif.ack = 1'b0;
    check("en_drop_after_ack", hif.en, 0);
    check("busy_in_serve", busy, 1);
  endtask

  task automatic serve(input int br, input int bc, input int n, input bit inject);
    int mism = 0;
    int first_i = -1;
    logic [31:0] first_got = '0;
    logic [31:0] exp_d = '0;
    logic [31:0] last = '0;
    int waddr;
    waddr = ref_addr(br, bc, 5, 0);
    for (int i = 0; i < n; i++) begin
      hif.row = 7'(i / W_WORDS);
      hif.col = 7'(i % W_WORDS);
      if (inject && i == 5) begin
        wr_en = 1'b1; wr_addr = AW'(waddr); wr_data = ~ref_mem[waddr];
      end
      step();
      wr_en = 1'b0;
      exp_d = ref_mem[ref_addr(br, bc, i / W_WORDS, i % W_WORDS)];
      if (hif.input_data !== exp_d) begin
        if (mism == 0) begin first_i = i; first_got = hif.input_data; end
        mism++;
      end
      if (inject && i == 5) check("wr_err_in_serve", wr_err, 1);
      last = exp_d;
    end
    check("serve_data_mismatches", 32'(mism), 0);
    if (mism != 0)
      $display("  first bad word at request %0d: got %0h want %0h", first_i, first_got,
               ref_mem[ref_addr(br, bc, first_i / W_WORDS, first_i % W_WORDS)]);
    if (n == W_ROWS * W_WORDS) begin
      check("busy_in_stream", busy, 1);
      hif.row = 7'($urandom_range(0, 79));
      hif.col = 7'($urandom_range(0, 19));
      step();
      check("input_data_holds", hif.input_data, last);
    end
  endtask

  task automatic stream(input int n, input int gap_pct, input bit rwd, input bit probe, input bit exp_ok);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) step();
      if (probe && i == n / 2) begin
        start = 1'b1; base_row = 8'd0; base_col = 7'd0;
        step();
        start = 1'b0;
        check("start_err_in_stream", start_err, 1);
        check("busy_after_stream_start", busy, 1);
      end
      hif.window_ready = 1'b1;
      step();
      hif.window_ready = 1'b0;
      if (cnt < SAT) cnt++;
    end
    check("win_count_before_done", win_count, 32'(cnt));
    hif.done = 1'b1; hif.window_ready = rwd;
    step();
    hif.done = 1'b0; hif.window_ready = 1'b0;
    if (rwd && cnt < SAT) cnt++;
    check("frame_done_pulse", frame_done, 1);
    check("count_ok", count_ok, 32'(exp_ok));
    check("win_count_at_done", win_count, 32'(cnt));
    check("busy_after_done", busy, 0);
    step();
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int nr;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; base_row = '0; base_col = '0;
    hif.ack = 1'b0; hif.row = '0; hif.col = '0; hif.window_ready = 1'b0; hif.done = 1'b0;
    step();
    step();
    check("rst_en", hif.en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_count_ok", count_ok, 0);
    check("rst_start_err", start_err, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_win_count", win_count, 0);
    check("rst_input_data", hif.input_data, 0);
`ifdef WINDOW_MEM_SERVER_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    rst = 1'b0;

    // Ramp load; the final write to word 0 shares its cycle with an accepted start.
    for (int a = 1; a < DEPTH; a++) write_word(a, 32'(a));
    do_start(0, 0, 1, 1, 0, 32'hA5A5_0000);
    handshake(3);
    serve(0, 0, W_ROWS * W_WORDS, 1);
    stream(10, 20, 0, 1, 0);

    // Reset in the middle of SERVE.
    do_start(0, 0, 1, 0, 0, 0);
    handshake(1);
    serve(0, 0, 100, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_en", hif.en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_win_count", win_count, 0);
    check("mid_rst_input_data", hif.input_data, 0);
    step();

    tbl[0] = '{br: 10,  bc: 5,   accept: 1, n: EXP_WIN,     rwd: 0, exp_ok: 1};
    tbl[1] = '{br: 161, bc: 0,   accept: 0, n: 0,           rwd: 0, exp_ok: 0};
    tbl[2] = '{br: 160, bc: 60,  accept: 1, n: EXP_WIN - 1, rwd: 1, exp_ok: 1};
    tbl[3] = '{br: 0,   bc: 61,  accept: 0, n: 0,           rwd: 0, exp_ok: 0};
    tbl[4] = '{br: 255, bc: 127, accept: 0, n: 0,           rwd: 0, exp_ok: 0};
    tbl[5] = '{br: int'($urandom_range(0, 160)), bc: int'($urandom_range(0, 60)), accept: 1,
               n: int'($urandom_range(0, 200)), rwd: 0, exp_ok: 0};
    for (int k = 0; k < 6; k++) begin
      do_start(tbl[k].br, tbl[k].bc, tbl[k].accept, 0, 0, 0);
      if (tbl[k].accept) begin
        handshake(int'($urandom_range(0, 3)));
        serve(tbl[k].br, tbl[k].bc, W_ROWS * W_WORDS, 0);
        stream(tbl[k].n, 20, tbl[k].rwd, 0, tbl[k].exp_ok);
      end
    end

    // Saturation of the window counter.
    do_start(0, 0, 1, 0, 0, 0);
    handshake(0);
    serve(0, 0, W_ROWS * W_WORDS, 0);
    stream(SAT + 4, 0, 1, 0, 0);

    // Reset in the middle of STREAM clears a nonzero count.
    do_start(20, 30, 1, 0, 0, 0);
    handshake(0);
    serve(20, 30, W_ROWS * W_WORDS, 0);
    for (int i = 0; i < 5; i++) begin
      hif.window_ready = 1'b1;
      step();
    end
    hif.window_ready = 1'b0;
    check("stream_count_before_rst", win_count, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stream_rst_win_count", win_count, 0);
    check("stream_rst_busy", busy, 0);
    step();

    // Random frame contents and random windows.
    for (int i = 0; i < 2000; i++) write_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
    for (int r = 0; r < 2; r++) begin
      int br;
      int bc;
      br = int'($urandom_range(0, 160));
      bc = int'($urandom_range(0, 60));
      nr = int'($urandom_range(0, 300));
      do_start(br, bc, 1, 0, 0, 0);
      handshake(int'($urandom_range(0, 2)));
      serve(br, bc, W_ROWS * W_WORDS, 0);
      stream(nr, 30, r[0], 0, 0);
    end

`ifdef WINDOW_MEM_SERVER_TIMEOUT_EN
    do_start(0, 0, 1, 0, 0, 0);
    for (int i = 1; i < 8192; i++) step();
    check("timeout_not_early", busy, 1);
    step();
    check("timeout_err_pulse", timeout_err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_en", hif.en, 0);
    step();
    check("timeout_err_one_cycle", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
